// File: rtl/sha_schedule.sv
// SHA-256 message-schedule generator: loads one 512-bit block, then streams
// (t, K[t], W[t]) for t = 0..63 from a 16-word sliding window.
module sha_schedule (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] M,
    input  logic         hold,
    output logic         busy,
    output logic         valid,
    output logic [5:0]   t,
    output logic [31:0]  Kt,
    output logic [31:0]  Wt,
    output logic         done
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 16;
    localparam int unsigned ROUNDS  = 64;
    localparam int unsigned T_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] K_TABLE [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   window_q [N_WORDS];
    logic [WORD_W-1:0]   window_d [N_WORDS];
    logic [T_W-1:0]      t_q, t_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   new_word;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Only one recurrence term per cycle: W[t+16] from the current window.
    always_comb begin
        new_word = ssig1(window_q[14]) + window_q[9] + ssig0(window_q[1]) + window_q[0];
    end

    // Next-state, window and round-counter logic.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        window_d = window_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < int'(N_WORDS); i++) begin
                        window_d[i] = M[WORD_W*(N_WORDS-1-i) +: WORD_W];
                    end
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    for (int i = 0; i < int'(N_WORDS) - 1; i++) begin
                        window_d[i] = window_q[i+1];
                    end
                    window_d[N_WORDS-1] = new_word;
                    t_d = t_q + T_W'(1);
                    if (t_q == T_W'(ROUNDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    for (int i = 0; i < int'(N_WORDS); i++) begin
                        window_d[i] = M[WORD_W*(N_WORDS-1-i) +: WORD_W];
                    end
                    t_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(N_WORDS); i++) begin
                window_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            window_q <= window_d;
        end
    end

    assign busy  = busy_q;
    assign valid = busy_q;
    assign done  = done_q;
    assign t     = t_q;
    assign Wt    = window_q[0];
    assign Kt    = K_TABLE[t_q];

endmodule
